// File: rtl/regfile_pkg.sv
// Shared encodings for the multi-port register file: write lane modes and clear-sweep states.
package regfile_pkg;

  localparam logic [2:0] PPP_A = 3'b000;
  localparam logic [2:0] PPP_U = 3'b001;
  localparam logic [2:0] PPP_D = 3'b010;
  localparam logic [2:0] PPP_E = 3'b011;
  localparam logic [2:0] PPP_O = 3'b100;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/regfile_lane_mask.sv
// Expands a 3-bit lane mode into a byte-granular bit mask (bit 0 = MSB numbering).
// Purely combinational, no handshake; reserved modes yield an empty mask.
module regfile_lane_mask
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [2:0]            ppp,
  output logic [DATA_WIDTH-1:0] mask
);

  localparam int NB = DATA_WIDTH / 8;

  always_comb begin
    logic lane_on;
    lane_on = 1'b0;
    mask    = '0;
    // Byte k counts from the MSB end, so byte 0 lives in the top 8 bits.
    for (int k = 0; k < NB; k++) begin
      case (ppp)
        PPP_A:   lane_on = 1'b1;
        PPP_U:   lane_on = (k < NB / 2);
        PPP_D:   lane_on = (k >= NB / 2);
        PPP_E:   lane_on = ((k % 2) == 0);
        PPP_O:   lane_on = ((k % 2) == 1);
        default: lane_on = 1'b0;
      endcase
      mask[DATA_WIDTH-1-8*k -: 8] = {8{lane_on}};
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file: 2 lane-masked write ports, NUM_RD bypassed read ports, pending scoreboard, clear sweep.
// Read latency 0 or 1 cycle; no backpressure, but writes/reservations are dropped while a sweep runs.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_RD       = 2,
  parameter int READ_LATENCY = 0,
  parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr0_en,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [2:0]                     wr0_ppp,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [2:0]                     wr1_ppp,
  input  logic [DATA_WIDTH-1:0]          wr1_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_pend,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  input  logic                           clr_req,
  output logic                           clr_busy,
  output logic                           clr_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mask0, mask1, m0_eff, m1_eff;
  logic                  wr0_hit, wr1_hit, rsv_act, busy;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q, pend_d;

  regfile_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask0 (.ppp(wr0_ppp), .mask(mask0));
  regfile_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask1 (.ppp(wr1_ppp), .mask(mask1));

  // Port 1 owns any lane both ports claim.
  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] d0,
    input logic [DATA_WIDTH-1:0] m0,
    input logic [DATA_WIDTH-1:0] d1,
    input logic [DATA_WIDTH-1:0] m1
  );
    return (cur & ~(m0 | m1)) | (d0 & m0 & ~m1) | (d1 & m1);
  endfunction

  assign busy     = (state_q == CLR_SWEEP);
  assign clr_busy = busy;
  assign clr_done = (state_q == CLR_DONE);

  always_comb begin
    m0_eff  = (wr0_en && !busy && (wr0_addr != '0)) ? mask0 : '0;
    m1_eff  = (wr1_en && !busy && (wr1_addr != '0)) ? mask1 : '0;
    wr0_hit = |m0_eff;
    wr1_hit = |m1_eff;
    rsv_act = rsv_en && !busy;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_SWEEP;
          ptr_d   = ADDR_WIDTH'(1);
        end
      end
      CLR_SWEEP: begin
        if (ptr_q == LAST_ADDR) state_d = CLR_DONE;
        else                    ptr_d   = ptr_q + 1'b1;
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = merge(regs_q[r],
                        wr0_data, (wr0_addr == ADDR_WIDTH'(r)) ? m0_eff : '0,
                        wr1_data, (wr1_addr == ADDR_WIDTH'(r)) ? m1_eff : '0);
    end
    pend_d = pend_q;
    for (int r = 0; r < DEPTH; r++) begin
      if ((wr0_hit && (wr0_addr == ADDR_WIDTH'(r))) ||
          (wr1_hit && (wr1_addr == ADDR_WIDTH'(r))))
        pend_d[r] = 1'b0;
    end
    // Reservation is applied after the write clear so it wins on the same register.
    if (rsv_act) pend_d[rsv_addr] = 1'b1;
    if (busy) begin
      regs_d[ptr_q] = '0;
      pend_d[ptr_q] = 1'b0;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rv;

    assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rv = '0;
      if (ra != '0)
        rv = merge(regs_q[ra],
                   wr0_data, (wr0_addr == ra) ? m0_eff : '0,
                   wr1_data, (wr1_addr == ra) ? m1_eff : '0);
    end

    assign rd_pend[i] = pend_q[ra] &
                        !((wr0_hit && (wr0_addr == ra)) || (wr1_hit && (wr1_addr == ra)));

    if (READ_LATENCY == 1) begin : g_reg
      logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
      assign rdat_d = rv;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) rdat_q <= '0;
        else        rdat_q <= rdat_d;
      end
      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rdat_q;
    end else begin : g_comb
      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: byte-lane reference model checked every cycle plus literal expectations.
module tb_regfile_mp_sb;
  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr0_en, wr1_en, rsv_en, clr_req;
  logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
  logic [2:0]        wr0_ppp, wr1_ppp;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_pend;
  logic              clr_busy, clr_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_RD(NRD), .READ_LATENCY(0)) dut (
    .clk(clk), .reset(reset),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_ppp(wr0_ppp), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_ppp(wr1_ppp), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  // Reference model state
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_pend [DEPTH];
  logic [DW-1:0] n_reg [DEPTH];
  bit            n_pend [DEPTH];
  bit            m_sweep, m_done;
  int            m_ptr;

  task automatic check64(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Byte k counted from the most significant byte.
  function automatic bit lane_on(input logic [2:0] p, input int k);
    case (p)
      3'd0:    return 1'b1;
      3'd1:    return k < 4;
      3'd2:    return k >= 4;
      3'd3:    return (k % 2) == 0;
      3'd4:    return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit w0_active();
    return wr0_en && !m_sweep && (wr0_addr != 0);
  endfunction

  function automatic bit w1_active();
    return wr1_en && !m_sweep && (wr1_addr != 0);
  endfunction

  function automatic logic [DW-1:0] written(input int a, input logic [DW-1:0] cur);
    logic [DW-1:0] v;
    v = cur;
    for (int k = 0; k < 8; k++) begin
      if (w1_active() && int'(wr1_addr) == a && lane_on(wr1_ppp, k))
        v[DW-1-8*k -: 8] = wr1_data[DW-1-8*k -: 8];
      else if (w0_active() && int'(wr0_addr) == a && lane_on(wr0_ppp, k))
        v[DW-1-8*k -: 8] = wr0_data[DW-1-8*k -: 8];
    end
    return v;
  endfunction

  function automatic bit hit(input int a);
    return (w0_active() && int'(wr0_addr) == a && wr0_ppp <= 3'd4) ||
           (w1_active() && int'(wr1_addr) == a && wr1_ppp <= 3'd4);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        m_reg[a]  = '0;
        m_pend[a] = 1'b0;
      end
      m_sweep = 1'b0;
      m_done  = 1'b0;
      m_ptr   = 0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        n_reg[a]  = (a == 0) ? '0 : written(a, m_reg[a]);
        n_pend[a] = (a != 0) && m_pend[a] && !hit(a);
      end
      if (rsv_en && !m_sweep && rsv_addr != 0) n_pend[rsv_addr] = 1'b1;
      if (m_sweep) begin
        n_reg[m_ptr]  = '0;
        n_pend[m_ptr] = 1'b0;
      end
      if (m_sweep) begin
        if (m_ptr == DEPTH - 1) begin
          m_sweep = 1'b0;
          m_done  = 1'b1;
        end else begin
          m_ptr++;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (clr_req) begin
        m_sweep = 1'b1;
        m_ptr   = 1;
      end
      m_reg  = n_reg;
      m_pend = n_pend;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NRD; i++) begin
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        check64($sformatf("model_rd_data%0d_r%0d", i, a), rd_data[i*DW +: DW],
                (a == 0) ? '0 : written(a, m_reg[a]));
        check1($sformatf("model_rd_pend%0d_r%0d", i, a), rd_pend[i], m_pend[a] && !hit(a));
      end
      check1("model_clr_busy", clr_busy, m_sweep);
      check1("model_clr_done", clr_done, m_done);
    end
  end

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    wr0_ppp = 3'd0; wr1_ppp = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic wr0(input int a, input logic [2:0] p, input logic [DW-1:0] d);
    wr0_en = 1'b1; wr0_addr = AW'(a); wr0_ppp = p; wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [2:0] p, input logic [DW-1:0] d);
    wr1_en = 1'b1; wr1_addr = AW'(a); wr1_ppp = p; wr1_data = d;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    idle();
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0; rd_addr = '0;
    #23 reset = 1'b1;
    step();

    @(negedge clk);
    check64("reset_rd0", rd(0), '0);
    check1("reset_pend0", rd_pend[0], 1'b0);
    check1("reset_busy", clr_busy, 1'b0);
    step();

    // Partial writes on r5
    wr0(5, 3'd0, 64'h0011223344556677); set_rd(0, 5);
    @(negedge clk); check64("bypass_a_r5", rd(0), 64'h0011223344556677);
    step();
    wr0(5, 3'd3, 64'hFFFFFFFFFFFFFFFF);
    step(); idle();
    @(negedge clk);
    check64("even_r5", rd(0), 64'hFF11FF33FF55FF77);
    check64("model_even_r5", m_reg[5], 64'hFF11FF33FF55FF77);
    step();
    wr0(5, 3'd1, 64'h0);
    step(); idle();
    @(negedge clk);
    check64("upper_r5", rd(0), 64'h00000000FF55FF77);
    check64("model_upper_r5", m_reg[5], 64'h00000000FF55FF77);
    step();

    // Same-address collision on r7
    wr0(7, 3'd0, 64'h1111111111111111); wr1(7, 3'd2, 64'h2222222222222222); set_rd(1, 7);
    @(negedge clk); check64("collide_bypass_r7", rd(1), 64'h1111111122222222);
    step(); idle();
    @(negedge clk); check64("collide_r7", rd(1), 64'h1111111122222222);
    step();

    // Scoreboard on r9
    rsv_en = 1'b1; rsv_addr = 5'd9; set_rd(0, 9);
    step(); idle();
    @(negedge clk); check1("rsv_pend_r9", rd_pend[0], 1'b1);
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9; wr0(9, 3'd0, 64'hDEADBEEF01234567);
    step(); idle();
    @(negedge clk);
    check1("rsv_wr_pend_r9", rd_pend[0], 1'b1);
    check64("rsv_wr_data_r9", rd(0), 64'hDEADBEEF01234567);
    step();
    wr0(9, 3'd0, 64'hCAFEF00D55AA55AA);
    @(negedge clk); check1("wr_comb_pend_r9", rd_pend[0], 1'b0);
    step(); idle();
    @(negedge clk);
    check1("wr_pend_r9", rd_pend[0], 1'b0);
    check1("model_pend_r9", m_pend[9], 1'b0);
    check64("wr_data_r9", rd(0), 64'hCAFEF00D55AA55AA);
    step();

    // R0 and reserved lane mode
    wr0(3, 3'd0, 64'hA5A5A5A5A5A5A5A5); rsv_en = 1'b1; rsv_addr = 5'd3;
    step(); idle();
    wr0(0, 3'd0, 64'hFFFFFFFFFFFFFFFF); wr1(3, 3'd6, 64'h0); set_rd(0, 0); set_rd(1, 3);
    @(negedge clk);
    check64("r0_bypass", rd(0), '0);
    check1("rsvd_comb_pend_r3", rd_pend[1], 1'b1);
    check64("rsvd_bypass_r3", rd(1), 64'hA5A5A5A5A5A5A5A5);
    step(); idle();
    @(negedge clk);
    check64("r0_stored", rd(0), '0);
    check1("rsvd_pend_r3", rd_pend[1], 1'b1);
    check64("rsvd_r3", rd(1), 64'hA5A5A5A5A5A5A5A5);
    step();

    // Fill, then clear sweep
    for (int a = 1; a < DEPTH; a++) begin
      wr0(a, 3'd0, {32'(a), 32'h5A5A5A5A});
      step();
    end
    idle(); set_rd(0, 31); set_rd(1, 20);
    @(negedge clk); check64("fill_r31", rd(0), {32'd31, 32'h5A5A5A5A});
    step();
    clr_req = 1'b1;
    step();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      if (c < 20) begin
        wr0(2, 3'd0, 64'hFFFFFFFFFFFFFFFF);
        rsv_en = 1'b1; rsv_addr = 5'd4;
      end
      clr_req = (c == 10);
      @(negedge clk);
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      step();
    end
    idle();
    checks++;
    if (busy_cnt != 31) begin
      failures++;
      $display("FAIL sweep_busy_cycles: got %0d expected 31", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL sweep_done_pulses: got %0d expected 1", done_cnt);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      set_rd(0, a); set_rd(1, a + 1);
      @(negedge clk);
      check64($sformatf("cleared_r%0d", a), rd(0), '0);
      check64($sformatf("cleared_r%0d", a + 1), rd(1), '0);
      check1($sformatf("cleared_pend_r%0d", a), rd_pend[0], 1'b0);
      check1($sformatf("cleared_pend_r%0d", a + 1), rd_pend[1], 1'b0);
      step();
    end

    // Asynchronous reset in the middle of a sweep
    wr0(5, 3'd0, 64'h0123456789ABCDEF); rsv_en = 1'b1; rsv_addr = 5'd6;
    step(); idle();
    set_rd(0, 5); set_rd(1, 6);
    clr_req = 1'b1;
    step(); idle();
    step(); step();
    #2 reset = 1'b0;
    #1;
    check64("async_rst_rd0", rd(0), '0);
    check64("async_rst_rd1", rd(1), '0);
    check1("async_rst_pend1", rd_pend[1], 1'b0);
    check1("async_rst_busy", clr_busy, 1'b0);
    check1("async_rst_done", clr_done, 1'b0);
    #7 reset = 1'b1;
    step();
    @(negedge clk);
    check64("post_rst_r5", rd(0), '0);
    check1("post_rst_busy", clr_busy, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
